cmd_control_mq: RTL
===================

// Module: cmd_control_mq
// PURPOSE
//  Multi-destination successor to the single-command robot controller. Queues up to DEPTH
//  GO destinations from the command UART, drives in_transit/go toward the queue head, pops on
//  a matching station ID and continues to the next stop. Drives the piezo buzzer while blocked.
//  Sits between UART cmd receiver / barcode ID reader and motion control / piezo driver.
// PARAMETERS
//  ID_W      6       destination/station ID bits used (1..6), from cmd[ID_W-1:0] and ID[ID_W-1:0]
//  DEPTH     4       destination queue depth (power of 2, >=2)
//  BUZZ_DIV  12500   buzz half-period in clk cycles (2 kHz at 50 MHz)
//  DWELL_CYC 2**25   dwell time at intermediate stops, clk cycles (DWELL_EN only)
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  cmd          in   8            command: [7:6] opcode, [ID_W-1:0] destination
//  cmd_rdy      in   1            cmd valid
//  clr_cmd_rdy  out  1            consume cmd (combinational, = cmd_rdy)
//  ID           in   8            station ID from barcode reader
//  ID_vld       in   1            ID valid
//  clr_ID_vld   out  1            consume ID (combinational, = ID_vld)
//  OK2Move      in   1            no obstacle
//  in_transit   out  1            registered; high in MOVE
//  go           out  1            in_transit & OK2Move (combinational)
//  buzz         out  1            buzzer drive
//  buzz_n       out  1            ~buzz
//  dest         out  ID_W         queue head (0 when empty)
//  q_cnt        out  clog2(DEPTH+1)  entries queued
//  q_full       out  1            q_cnt == DEPTH
// BEHAVIOUR
//  Reset: queue empty, state IDLE, in_transit=0, go=0, buzz=0, buzz_n=1, dest=0, q_cnt=0, counters 0.
//  Opcodes (every cmd_rdy consumed same cycle, effect visible next cycle):
//   01 GO   : push cmd[ID_W-1:0]; if q_full, dropped silently (queue unchanged)
//   00 STOP : flush queue, state -> IDLE, in_transit=0
//   10 SKIP : pop head if non-empty; no-op if empty
//   11      : consumed, ignored
//  States:
//   IDLE : in_transit=0. q_cnt!=0 -> MOVE (GO into empty queue: in_transit high 1 cycle after cmd_rdy).
//   MOVE : in_transit=1. ID_vld with ID[7:6]==00 and ID[ID_W-1:0]==dest -> pop;
//          queue then empty -> IDLE, else stay MOVE (DWELL w/ DWELL_EN). Other IDs consumed, ignored.
//          SKIP emptying queue -> IDLE.
//  Simultaneous: GO push + ID-match pop same cycle -> both, q_cnt unchanged, new head next.
//   STOP beats everything same cycle (flush, push discarded). SKIP + ID-match same cycle -> one pop only.
//   GO while full + pop same cycle -> push accepted.
//  Queue: circular, wr/rd pointers wrap at DEPTH; order FIFO.
//  Buzzer: enabled iff in_transit & ~OK2Move. Counter counts 0..BUZZ_DIV-1, buzz toggles at wrap.
//   Disabled: counter cleared, buzz=0, buzz_n=1 next cycle. buzz first rises BUZZ_DIV cycles after enable.
//  Reset mid-operation: immediate return to reset values, queue contents lost.
// CONFIGURATION
//  CMD_CTRL_DWELL_EN defined: DWELL state added. Pop leaving q_cnt!=0 -> DWELL; in_transit=0, go=0,
//   buzz off; counter runs DWELL_CYC cycles then -> MOVE. STOP in DWELL -> flush, IDLE;
//   SKIP emptying queue -> IDLE; GO pushes normally.
//  Undefined: no DWELL state or counter; intermediate pop stays in MOVE, in_transit continuously high.
// TESTING (bench: ID_W=6, DEPTH=4, BUZZ_DIV=4, DWELL_CYC=8)
//  1 Reset, GO cmd=8'h45 -> clr_cmd_rdy same cycle; next cycle q_cnt=1, dest=5, in_transit=1; go follows OK2Move.
//  2 GO 05,0A,0F; ID=8'h05 ID_vld -> clr_ID_vld; q_cnt 3->2, dest=0A, in_transit stays 1 (no DWELL_EN);
//    ID=8'h4A (bad [7:6]) ignored; ID=0A, then 0F -> IDLE, in_transit=0.
//  3 Five GOs 01..05 -> q_full=1, q_cnt=4, 05 dropped; pops yield 01,02,03,04 in order.
//  4 MOVE, OK2Move=0 -> go=0, buzz toggles every 4 cycles, buzz_n=~buzz; OK2Move=1 -> buzz=0 next cycle.
//  5 q_cnt=3, STOP and matching ID_vld same cycle -> q_cnt=0, IDLE; GO+match same cycle -> q_cnt unchanged.
//  6 DWELL_EN: match with 2 queued -> in_transit=0 for 8 cycles, then 1; rst_n low mid-DWELL -> reset values.

Source files
------------

// File: rtl/cmd_control_mq.sv
// Multi-destination robot command controller: FIFO of GO destinations, MOVE toward the head,
// pop on matching station ID, piezo buzz while blocked. Optional dwell stop: CMD_CTRL_DWELL_EN.
module cmd_control_mq #(
    parameter int unsigned ID_W      = 6,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BUZZ_DIV  = 12500,
    parameter int unsigned DWELL_CYC = 2**25
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   cmd,
    input  logic                         cmd_rdy,
    output logic                         clr_cmd_rdy,
    input  logic [7:0]                   ID,
    input  logic                         ID_vld,
    output logic                         clr_ID_vld,
    input  logic                         OK2Move,
    output logic                         in_transit,
    output logic                         go,
    output logic                         buzz,
    output logic                         buzz_n,
    output logic [ID_W-1:0]              dest,
    output logic [$clog2(DEPTH+1)-1:0]   q_cnt,
    output logic                         q_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BUZZ_DIV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1
`ifdef CMD_CTRL_DWELL_EN
        ,DWELL = 2'd2
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            in_transit_q;
    logic [BW-1:0]   buzz_cnt;
    logic            buzz_q;
    logic            q_empty, is_go, is_stop, is_skip, id_match, do_pop, do_push, buzz_en;

    // Command and ID decode; STOP overrides any push or pop in the same cycle.
    always_comb begin
        q_empty  = (cnt_q == '0);
        is_go    = cmd_rdy && (cmd[7:6] == 2'b01);
        is_stop  = cmd_rdy && (cmd[7:6] == 2'b00);
        is_skip  = cmd_rdy && (cmd[7:6] == 2'b10);
        id_match = (state == MOVE) && !q_empty && ID_vld &&
                   (ID[7:6] == 2'b00) && (ID[ID_W-1:0] == mem[rd_ptr]);
        do_pop   = !is_stop && !q_empty && (is_skip || id_match);
        do_push  = !is_stop && is_go && ((cnt_q != CW'(DEPTH)) || do_pop);
        cnt_nxt  = is_stop ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

`ifdef CMD_CTRL_DWELL_EN
    localparam int DW = $clog2(DWELL_CYC + 1);
    logic [DW-1:0] dwell_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dwell_cnt <= '0;
        else        dwell_cnt <= (state == DWELL) ? dwell_cnt + DW'(1) : '0;
    end
`endif

    // NOTE: next-state logic assigns its default first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cnt_nxt != '0) state_nxt = MOVE;
            MOVE: begin
                if (cnt_nxt == '0) state_nxt = IDLE;
`ifdef CMD_CTRL_DWELL_EN
                else if (id_match) state_nxt = DWELL;
`endif
            end
`ifdef CMD_CTRL_DWELL_EN
            DWELL: begin
                if (cnt_nxt == '0)                           state_nxt = IDLE;
                else if (dwell_cnt == DW'(DWELL_CYC - 1))    state_nxt = MOVE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_transit_q <= 1'b0;
            cnt_q        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state        <= state_nxt;
            in_transit_q <= (state_nxt == MOVE);
            cnt_q        <= cnt_nxt;
            if (is_stop) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= cmd[ID_W-1:0];
    end

    // Buzzer half-period divider, held cleared whenever the robot is not blocked in transit.
    assign buzz_en = in_transit_q && !OK2Move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (!buzz_en) begin
            buzz_cnt <= '0;
            buzz_q   <= 1'b0;
        end else if (buzz_cnt == BW'(BUZZ_DIV - 1)) begin
            buzz_cnt <= '0;
            buzz_q   <= ~buzz_q;
        end else begin
            buzz_cnt <= buzz_cnt + BW'(1);
        end
    end

    assign clr_cmd_rdy = cmd_rdy;
    assign clr_ID_vld  = ID_vld;
    assign in_transit  = in_transit_q;
    assign go          = in_transit_q & OK2Move;
    assign buzz        = buzz_q;
    assign buzz_n      = ~buzz_q;
    assign dest        = q_empty ? '0 : mem[rd_ptr];
    assign q_cnt       = cnt_q;
    assign q_full      = (cnt_q == CW'(DEPTH));

endmodule
